// File: rtl/xgmii_pkg.sv
// Shared XGMII definitions: control characters, fixed words, FIFO word
// layout and the transmit framer state encoding.
package xgmii_pkg;

   localparam logic [7:0] XGMII_IDLE     = 8'h07;
   localparam logic [7:0] XGMII_START    = 8'hFB;
   localparam logic [7:0] XGMII_TERM     = 8'hFD;
   localparam logic [7:0] XGMII_ERROR    = 8'hFE;
   localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
   localparam logic [7:0] XGMII_SFD      = 8'hD5;

   localparam logic [63:0] IDLE_WORD     = {8{XGMII_IDLE}};
   localparam logic [7:0]  IDLE_CTL      = 8'hFF;
   // Start in lane 0, six preamble bytes, SFD in lane 7.
   localparam logic [63:0] PREAMBLE_WORD = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START};
   localparam logic [7:0]  PREAMBLE_CTL  = 8'h01;
   // Terminate in lane 0 after a frame that filled its last word exactly.
   localparam logic [63:0] TERM_WORD     = {{7{XGMII_IDLE}}, XGMII_TERM};
   localparam logic [63:0] ERROR_WORD    = {8{XGMII_ERROR}};

   // FIFO word layout.
   localparam int FIFO_EOF_BIT = 71;
   localparam int FIFO_LEN_HI  = 66;
   localparam int FIFO_LEN_LO  = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_DATA,
      ST_TERM,
      ST_DRAIN,
      ST_IPG
   } tx_state_e;

endpackage

// File: rtl/xgmii_tx_termgen.sv
// Merges the terminate character into the last word of a frame: lanes below
// nbytes carry data, lane nbytes carries FD and higher lanes carry idle.
// nbytes = 8 passes the word through as pure data.
module xgmii_tx_termgen
   import xgmii_pkg::*;
(
   input  logic [63:0] data_i,
   input  logic [3:0]  nbytes_i,
   output logic [63:0] txd_o,
   output logic [7:0]  txc_o
);

   for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign txd_o[gi*8 +: 8] = (4'(gi) <  nbytes_i) ? data_i[gi*8 +: 8] :
                                (4'(gi) == nbytes_i) ? XGMII_TERM : XGMII_IDLE;
      assign txc_o[gi]        = (4'(gi) >= nbytes_i);
   end

endmodule

// File: rtl/xgmii_tx_framer.sv
// XGMII transmit framer: pops store-and-forward frames from a FWFT FIFO and
// wraps them with preamble, terminate and inter-packet gap. An underrun emits
// an error word and the remainder of the frame is discarded.
module xgmii_tx_framer
   import xgmii_pkg::*;
#(
   parameter int IPG_WORDS = 2
)
(
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [71:0] dout,
   input  logic        empty,
   output logic        rd_en,
   input  logic        frame_avail,
   input  logic        tx_en,
   output logic [63:0] xgmii_txd,
   output logic [7:0]  xgmii_txc,
   output logic [31:0] tx_frame_cnt,
   output logic        tx_underrun
);

   localparam int IPG_W = $clog2(IPG_WORDS + 1);
   localparam logic [IPG_W-1:0] IPG_LOAD = IPG_W'(IPG_WORDS);

   tx_state_e        state_q, state_d;
   logic [IPG_W-1:0] ipg_q, ipg_d;
   logic [63:0]      txd_q, txd_d;
   logic [7:0]       txc_q, txc_d;
   logic             underrun_q, underrun_d;
   logic [31:0]      frame_cnt_q;
   logic             term_d;

   logic             head_eof;
   logic             head_full;
   logic [3:0]       head_nbytes;
   logic [63:0]      term_txd;
   logic [7:0]       term_txc;
   logic             unused_ctl;

   assign head_eof    = dout[FIFO_EOF_BIT];
   assign head_full   = (dout[FIFO_LEN_HI:FIFO_LEN_LO] == 3'd7);
   assign head_nbytes = {1'b0, dout[FIFO_LEN_HI:FIFO_LEN_LO]} + 4'd1;
   // Bits [70:67] of the FIFO word carry nothing for the transmitter.
   assign unused_ctl  = ^dout[70:67];

   xgmii_tx_termgen u_termgen (
      .data_i   (dout[63:0]),
      .nbytes_i (head_nbytes),
      .txd_o    (term_txd),
      .txc_o    (term_txc)
   );

   // Next state, next output word and FIFO pop; the word chosen here is what
   // appears on the XGMII pins in the following cycle.
   always_comb begin
      state_d    = state_q;
      ipg_d      = ipg_q;
      txd_d      = IDLE_WORD;
      txc_d      = IDLE_CTL;
      underrun_d = 1'b0;
      term_d     = 1'b0;
      rd_en      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tx_en && frame_avail && !empty) begin
               state_d = ST_PRE;
               txd_d   = PREAMBLE_WORD;
               txc_d   = PREAMBLE_CTL;
            end
         end
         ST_PRE, ST_DATA: begin
            rd_en = !empty;
            if (empty) begin
               txd_d      = ERROR_WORD;
               txc_d      = 8'hFF;
               underrun_d = 1'b1;
               state_d    = ST_DRAIN;
            end else if (!head_eof) begin
               txd_d   = dout[63:0];
               txc_d   = 8'h00;
               state_d = ST_DATA;
            end else if (head_full) begin
               // No room for FD in this word; it goes out alone next.
               txd_d   = dout[63:0];
               txc_d   = 8'h00;
               state_d = ST_TERM;
            end else begin
               txd_d   = term_txd;
               txc_d   = term_txc;
               term_d  = 1'b1;
               ipg_d   = IPG_LOAD;
               state_d = ST_IPG;
            end
         end
         ST_TERM: begin
            txd_d   = TERM_WORD;
            txc_d   = 8'hFF;
            term_d  = 1'b1;
            ipg_d   = IPG_LOAD;
            state_d = ST_IPG;
         end
         ST_DRAIN: begin
            rd_en = !empty;
            if (!empty && head_eof) begin
               ipg_d   = IPG_LOAD;
               state_d = ST_IPG;
            end
         end
         ST_IPG: begin
            if (ipg_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               ipg_d = ipg_q - IPG_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered XGMII outputs; reset abandons any frame in flight.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         ipg_q      <= '0;
         txd_q      <= IDLE_WORD;
         txc_q      <= IDLE_CTL;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ipg_q      <= ipg_d;
         txd_q      <= txd_d;
         txc_q      <= txc_d;
         underrun_q <= underrun_d;
      end
   end

   // Frame counter advances together with the word carrying FD; wraps freely.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         frame_cnt_q <= '0;
      end else if (term_d) begin
         frame_cnt_q <= frame_cnt_q + 32'd1;
      end
   end

   assign xgmii_txd    = txd_q;
   assign xgmii_txc    = txc_q;
   assign tx_underrun  = underrun_q;
   assign tx_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Directed bench for xgmii_tx_framer with a small FWFT FIFO model in front.
module tb_xgmii_tx_framer;

   localparam logic [63:0] IDLE_W = 64'h0707070707070707;
   localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
   localparam logic [63:0] TERM_W = 64'h07070707070707FD;
   localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;

   logic        clk;
   logic        sys_rst;
   logic [71:0] dout;
   logic        empty;
   logic        rd_en;
   logic        frame_avail;
   logic        tx_en;
   logic [63:0] xgmii_txd;
   logic [7:0]  xgmii_txc;
   logic [31:0] tx_frame_cnt;
   logic        tx_underrun;

   int n_checks = 0;
   int n_fail   = 0;

   // FWFT FIFO model; flushed by the same reset as the framer.
   logic [71:0] mem [0:255];
   logic [7:0]  wp;
   logic [7:0]  rp;
   logic        stall;

   assign empty = (rp == wp) || stall;
   assign dout  = mem[rp];

   always @(posedge clk) begin
      if (sys_rst) rp <= wp;
      else if (rd_en) rp <= rp + 8'd1;
   end

   xgmii_tx_framer #(.IPG_WORDS(2)) dut (
      .sys_clk      (clk),
      .sys_rst      (sys_rst),
      .dout         (dout),
      .empty        (empty),
      .rd_en        (rd_en),
      .frame_avail  (frame_avail),
      .tx_en        (tx_en),
      .xgmii_txd    (xgmii_txd),
      .xgmii_txc    (xgmii_txc),
      .tx_frame_cnt (tx_frame_cnt),
      .tx_underrun  (tx_underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] wd(input int f, input int j);
      return {4'hA, 4'(f), 8'(j), 48'h112233445566};
   endfunction

   task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_word(input string tag, input logic u, input logic [7:0] c, input logic [63:0] d);
      @(negedge clk);
      chk(tag, {tx_underrun, xgmii_txc, xgmii_txd}, {u, c, d});
   endtask

   task automatic idle_cycles(input string tag, input int n);
      for (int i = 0; i < n; i++) expect_word(tag, 1'b0, 8'hFF, IDLE_W);
   endtask

   task automatic push(input logic eof, input logic [2:0] len, input logic [63:0] d);
      mem[wp] = {eof, 4'h5, len, d};
      wp = wp + 8'd1;
   endtask

   initial begin
      logic [63:0] w;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      wp = 8'd0; stall = 1'b0;
      sys_rst = 1'b1; tx_en = 1'b0; frame_avail = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_word", {tx_underrun, xgmii_txc, xgmii_txd}, {1'b0, 8'hFF, IDLE_W});
      chk("rst_rd_en", 73'(rd_en), 73'd0);
      chk("rst_cnt", 73'(tx_frame_cnt), 73'd0);
      sys_rst = 1'b0;

      // 64-byte frame: eight full words, then a lone terminate word
      for (int j = 0; j < 8; j++) push(j == 7, (j == 7) ? 3'd7 : 3'd0, wd(1, j));
      frame_avail = 1'b1; tx_en = 1'b1;
      expect_word("t1_pre", 1'b0, 8'h01, PRE_W);
      chk("t1_pre_rd_en", 73'(rd_en), 73'd1);
      for (int j = 0; j < 8; j++) expect_word($sformatf("t1_d%0d", j), 1'b0, 8'h00, wd(1, j));
      expect_word("t1_term", 1'b0, 8'hFF, TERM_W);
      chk("t1_cnt", 73'(tx_frame_cnt), 73'd1);
      idle_cycles("t1_ipg", 4);

      // 61-byte frame: last word has five bytes, FD in lane 5
      for (int j = 0; j < 8; j++) push(j == 7, (j == 7) ? 3'd4 : 3'd0, wd(2, j));
      expect_word("t2_pre", 1'b0, 8'h01, PRE_W);
      for (int j = 0; j < 7; j++) expect_word($sformatf("t2_d%0d", j), 1'b0, 8'h00, wd(2, j));
      w = wd(2, 7);
      expect_word("t2_last", 1'b0, 8'hE0, {16'h0707, 8'hFD, w[39:0]});
      chk("t2_cnt", 73'(tx_frame_cnt), 73'd2);
      idle_cycles("t2_no_term", 4);

      // Back-to-back frames: A ends with 3 bytes, B ends full
      for (int j = 0; j < 3; j++) push(j == 2, (j == 2) ? 3'd2 : 3'd0, wd(3, j));
      for (int j = 0; j < 2; j++) push(j == 1, (j == 1) ? 3'd7 : 3'd0, wd(4, j));
      expect_word("t3_pre_a", 1'b0, 8'h01, PRE_W);
      expect_word("t3_a0", 1'b0, 8'h00, wd(3, 0));
      expect_word("t3_a1", 1'b0, 8'h00, wd(3, 1));
      w = wd(3, 2);
      expect_word("t3_a_last", 1'b0, 8'hF8, {32'h07070707, 8'hFD, w[23:0]});
      chk("t3_cnt_a", 73'(tx_frame_cnt), 73'd3);
      idle_cycles("t3_gap", 3);
      expect_word("t3_pre_b", 1'b0, 8'h01, PRE_W);
      expect_word("t3_b0", 1'b0, 8'h00, wd(4, 0));
      expect_word("t3_b1", 1'b0, 8'h00, wd(4, 1));
      expect_word("t3_b_term", 1'b0, 8'hFF, TERM_W);
      chk("t3_cnt_b", 73'(tx_frame_cnt), 73'd4);
      idle_cycles("t3_after", 4);

      // Underrun after the third word of a 10-word frame
      for (int j = 0; j < 10; j++) push(j == 9, (j == 9) ? 3'd7 : 3'd0, wd(5, j));
      expect_word("t4_pre", 1'b0, 8'h01, PRE_W);
      for (int j = 0; j < 3; j++) expect_word($sformatf("t4_d%0d", j), 1'b0, 8'h00, wd(5, j));
      stall = 1'b1;
      expect_word("t4_err", 1'b1, 8'hFF, ERR_W);
      idle_cycles("t4_stall", 2);
      stall = 1'b0;
      idle_cycles("t4_drain", 12);
      chk("t4_fifo_drained", 73'(rp), 73'(wp));
      chk("t4_cnt", 73'(tx_frame_cnt), 73'd4);

      // tx_en dropped during the preamble: frame still completes
      push(1'b0, 3'd0, wd(6, 0));
      push(1'b1, 3'd5, wd(6, 1));
      expect_word("t5_pre", 1'b0, 8'h01, PRE_W);
      tx_en = 1'b0;
      expect_word("t5_d0", 1'b0, 8'h00, wd(6, 0));
      w = wd(6, 1);
      expect_word("t5_last", 1'b0, 8'hC0, {8'h07, 8'hFD, w[47:0]});
      chk("t5_cnt", 73'(tx_frame_cnt), 73'd5);
      idle_cycles("t5_after", 4);

      // tx_en low with a frame waiting: idles only, no pops
      for (int j = 0; j < 4; j++) push(j == 3, (j == 3) ? 3'd7 : 3'd0, wd(7, j));
      for (int i = 0; i < 6; i++) begin
         expect_word("t5_hold_word", 1'b0, 8'hFF, IDLE_W);
         chk("t5_hold_rd_en", 73'(rd_en), 73'd0);
      end

      // Reset while in DATA abandons the frame
      tx_en = 1'b1;
      expect_word("t6_pre", 1'b0, 8'h01, PRE_W);
      expect_word("t6_d0", 1'b0, 8'h00, wd(7, 0));
      expect_word("t6_d1", 1'b0, 8'h00, wd(7, 1));
      sys_rst = 1'b1;
      expect_word("t6_rst_word", 1'b0, 8'hFF, IDLE_W);
      chk("t6_rst_rd_en", 73'(rd_en), 73'd0);
      chk("t6_rst_cnt", 73'(tx_frame_cnt), 73'd0);
      sys_rst = 1'b0;
      idle_cycles("t6_after", 2);

      // Counter wrap from all-ones
      force dut.frame_cnt_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.frame_cnt_q;
      push(1'b1, 3'd3, wd(8, 0));
      expect_word("t7_pre", 1'b0, 8'h01, PRE_W);
      w = wd(8, 0);
      expect_word("t7_last", 1'b0, 8'hF0, {24'h070707, 8'hFD, w[31:0]});
      chk("t7_cnt_wrap", 73'(tx_frame_cnt), 73'd0);
      idle_cycles("t7_after", 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/xgmii_tx_framer.md
# xgmii_tx_framer

Transmit-side XGMII framer: pops store-and-forward Ethernet frames from a first-word-fall-through 72-bit FIFO and drives one 10G XGMII TX port. It inserts start/preamble/SFD, the terminate character, and a minimum inter-packet gap. It handles FIFO underrun by emitting an XGMII error and dropping the rest of the frame. It is the counterpart of the XGMII receive-to-FIFO path, and sits between each port's egress FIFO and its PHY TX interface in `l2switch`.

## Interface
- `IPG_WORDS`, default 2: full idle words guaranteed after the terminate word (≥1).
- `sys_clk` in 1: XGMII TX clock (156.25 MHz); all logic is single-clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `dout` in 72: FIFO head word.
  - [63:0] frame bytes, lane 0 = first byte on the wire.
  - [71] eof.
  - [66:64] valid bytes − 1, meaningful only when eof.
  - [70:67] ignored.
- `empty` in 1: FIFO empty; `dout` is valid whenever `empty` = 0 (FWFT).
- `rd_en` out 1: pop the head word.
- `frame_avail` in 1: at least one complete frame is in the FIFO.
- `tx_en` in 1: permits starting new frames.
- `xgmii_txd` out 64: TX data.
- `xgmii_txc` out 8: TX control, bit i covers lane i.
- `tx_frame_cnt` out 32: frames terminated normally.
- `tx_underrun` out 1: one-cycle pulse when an error word is emitted.

## Operation
- FIFO frames carry DA through FCS; the framer never computes CRC.
- Constants: idle 0x07, start 0xFB, terminate 0xFD, error 0xFE, preamble 0x55, SFD 0xD5.
- Idle word: txd = 0x0707070707070707, txc = 0xFF.
- FSM states: IDLE, PRE, DATA, TERM, DRAIN, IPG.
- IDLE:
  - Outputs an idle word.
  - If `tx_en && frame_avail && !empty`, go to PRE.
- PRE:
  - Outputs the preamble word: txd = 0xD5555555555555FB, txc = 0x01.
  - Asserts `rd_en = !empty`.
  - If `empty`, go to DRAIN with an error word.
  - Otherwise pop the first word and go to DATA.
- DATA:
  - Asserts `rd_en = !empty`.
  - A popped non-eof word is output next cycle with txc = 0x00.
  - Popped eof word with n valid bytes, n < 8:
    - Output next cycle: lanes 0..n−1 data (txc 0), lane n = FD (txc 1), lanes > n = 07 (txc 1).
    - Then go to IPG.
  - Popped eof word with n = 8: output it as full data, then go to TERM.
  - `empty` seen in DATA (underrun): output next cycle is 0xFEFE…FE with txc 0xFF, `tx_underrun` pulses, go to DRAIN.
- TERM:
  - Outputs txd = 0x07070707070707FD, txc = 0xFF.
  - Go to IPG.
- DRAIN:
  - Outputs idle words with `rd_en = !empty`.
  - Discards words until an eof word is popped, then go to IPG.
  - `tx_frame_cnt` is not incremented.
- IPG:
  - Outputs exactly `IPG_WORDS` idle words, counted by a down-counter, then go to IDLE.
  - A new start is evaluated only in IDLE.
- `tx_frame_cnt` increments by 1 in the cycle the terminate character (FD) is driven, and wraps 0xFFFFFFFF → 0.
- `tx_en` deasserted mid-frame has no effect until IDLE; the current frame completes.
- Frames always start on lane 0. There is no deficit-idle accounting.

## Timing
- `xgmii_txd`, `xgmii_txc`, and `tx_underrun` are registered. `rd_en` is combinational from state and `empty`.
- Reset:
  - Outputs: idle word, `rd_en` 0, `tx_frame_cnt` 0, `tx_underrun` 0.
  - State: IDLE, IPG counter 0.
  - A reset mid-frame abandons the frame immediately (no FD or FE is driven). Leftover FIFO words are the FIFO owner's concern; the FIFO is reset by the same `sys_rst`.
- Start condition true at cycle t:
  - Preamble is on the outputs at t+1.
  - First pop occurs at t+1; first data word is on the outputs at t+2.
- Sustained throughput is one word per cycle with no bubbles inside a frame.
- The error word appears one cycle after the cycle `empty` was sampled high in PRE/DATA.
- Back-to-back frames, n < 8: the next preamble appears `IPG_WORDS` + 2 cycles after the terminate word (IPG words, then one IDLE cycle).

## Structure
- Shared package `xgmii_pkg`:
  - XGMII character constants.
  - Idle-word constant.
  - FIFO field positions (eof bit 71, length [66:64]).
  - FSM state enum.
- Sub-module `xgmii_tx_termgen` (combinational): takes a data word and n (1..8) and returns the terminate-lane merged {txc, txd}. It is reusable by the GMII-bridge path.
- Everything else is a single-process FSM plus the output register.

## Test plan
- 64-byte frame (8 words, last eof with [66:64] = 7), IPG_WORDS = 2:
  - Preamble, then 8 data words.
  - Then TERM word 0x07070707070707FD / 0xFF.
  - Then 2 idle words.
  - `tx_frame_cnt` = 1.
- 61-byte frame (last word eof, n = 5):
  - Last word txc = 0xE0.
  - Lane 5 = FD, lanes 6–7 = 07.
  - No TERM word is emitted.
- Two queued frames with `frame_avail` held high:
  - Second preamble exactly IPG_WORDS + 2 cycles after the first terminate.
  - No data bubbles inside either frame.
- Underrun: assert `empty` for 3 cycles after word 3 of a 10-word frame.
  - Word 4 output is all-FE with txc 0xFF; `tx_underrun` pulses once.
  - Remaining words are popped silently until eof, followed by idles.
  - `tx_frame_cnt` is unchanged.
- `tx_en` dropped during the preamble: the frame completes. `tx_en` held low in IDLE with `frame_avail` = 1: idles only, `rd_en` = 0.
- `sys_rst` asserted in DATA: the next cycle shows an idle word, `rd_en` = 0, counters 0. Preload `tx_frame_cnt` to 0xFFFFFFFF and send one frame: the count reads 0.
